// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side burst consumer.
// Contents: burst FSM state enum, default widths/burst length, and the
// level-width helper (used-word count plus one bit so "full" is representable).
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StFlush
  } rd_state_e;

  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefUsedwW   = 3;
  localparam int unsigned DefBurstLen = 4;
  localparam int unsigned DefLevelW   = DefUsedwW + 1;

  // rdusedw wraps to 0 when the FIFO is full, so the level needs one extra bit.
  function automatic int unsigned level_w(input int unsigned usedw_w);
    return usedw_w + 1;
  endfunction

endpackage

// File: rtl/obuf_sync_fifo.sv
// Single-clock show-ahead FIFO used as the output buffer of fifo_burst_reader.
// Ports:
//   clk, aclr_n   clock and asynchronous active-low reset
//   push, wdata   write side; a push is accepted when not full, or when full
//                 and a pop happens in the same cycle
//   pop           read side; advances the head when not empty
//   rdata         head entry (valid while !empty)
//   empty         no entries stored
//   count         number of stored entries (0..DEPTH)
module obuf_sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // The pop frees the slot first, so push-while-full is fine when popping.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for the dual-clock sample FIFO (read clock domain only).
// Waits for BURST_LEN words to be buffered, issues exactly BURST_LEN rdreq
// pulses, absorbs the FIFO's one-cycle read latency and streams the words out
// on a valid/ready interface with a last-of-burst marker.
// Ports:
//   rdclk, aclr_n         read clock, asynchronous active-low reset
//   fifo_q                FIFO read data, valid one cycle after fifo_rdreq
//   fifo_rdempty/rdfull   FIFO flags
//   fifo_rdusedw          FIFO used-word count (0 when full)
//   fifo_rdreq            FIFO read request
//   out_data/valid/ready  downstream stream
//   out_last              final word of a burst
//   burst_done            pulse on acceptance of the final word
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned USEDW_W    = DefUsedwW,
  parameter int unsigned BURST_LEN  = DefBurstLen,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic               rdclk,
  input  logic               aclr_n,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic               fifo_rdempty,
  input  logic               fifo_rdfull,
  input  logic [USEDW_W-1:0] fifo_rdusedw,
  output logic               fifo_rdreq,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               burst_done
);

  localparam int unsigned LvlW = level_w(USEDW_W);
  localparam int unsigned CntW = $clog2(OBUF_DEPTH) + 1;

  localparam logic [LvlW-1:0] FullLevel  = LvlW'(1 << USEDW_W);
  localparam logic [LvlW-1:0] BurstLenL  = LvlW'(BURST_LEN);
  localparam logic [LvlW-1:0] LastIdx    = LvlW'(BURST_LEN - 1);
  localparam logic [CntW-1:0] ObufDepthL = CntW'(OBUF_DEPTH);

  rd_state_e         state_q;
  logic [LvlW-1:0]   issued_q;
  logic              pipe_valid_q;
  logic              pipe_last_q;

  logic [LvlW-1:0]   level;
  logic [CntW-1:0]   ob_count;
  logic              ob_empty;
  logic [DATA_W:0]   ob_rdata;
  logic              credit_ok;
  logic              accept;

  assign level = fifo_rdfull ? FullLevel : {1'b0, fifo_rdusedw};

  // Buffered words plus the word in the read pipe must leave room for one more.
  assign credit_ok = (ob_count + {{(CntW-1){1'b0}}, pipe_valid_q}) < ObufDepthL;

  // Request is decoded from registered state but gated by the live empty flag,
  // so a request is never presented against an empty FIFO.
  always_comb begin
    fifo_rdreq = 1'b0;
    if (state_q == StBurst && issued_q < BurstLenL && !fifo_rdempty && credit_ok) begin
      fifo_rdreq = 1'b1;
    end
  end

  assign out_valid  = ~ob_empty;
  assign accept     = out_valid & out_ready;
  assign out_data   = out_valid ? ob_rdata[DATA_W-1:0] : '0;
  assign out_last   = out_valid & ob_rdata[DATA_W];
  assign burst_done = accept & out_last;

  always_ff @(posedge rdclk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= StIdle;
      issued_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Read pipe is checked too so a new burst never overlaps a draining one.
          if (level >= BurstLenL && ob_empty && !pipe_valid_q) begin
            state_q  <= StBurst;
            issued_q <= '0;
          end
        end
        StBurst: begin
          if (fifo_rdreq) begin
            issued_q <= issued_q + LvlW'(1);
            if (issued_q == LastIdx) state_q <= StFlush;
          end
        end
        StFlush: begin
          if (burst_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // One-stage pipe matching the FIFO read latency: fifo_q is valid the cycle
  // after rdreq, which is exactly when pipe_valid_q is high.
  always_ff @(posedge rdclk or negedge aclr_n) begin
    if (!aclr_n) begin
      pipe_valid_q <= 1'b0;
      pipe_last_q  <= 1'b0;
    end else begin
      pipe_valid_q <= fifo_rdreq;
      pipe_last_q  <= fifo_rdreq & (issued_q == LastIdx);
    end
  end

  obuf_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk    (rdclk),
    .aclr_n (aclr_n),
    .push   (pipe_valid_q),
    .wdata  ({pipe_last_q, fifo_q}),
    .pop    (accept),
    .rdata  (ob_rdata),
    .empty  (ob_empty),
    .count  (ob_count)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  logic        rdclk = 1'b0;
  logic        aclr_n = 1'b0;
  logic [15:0] fifo_q = '0;
  logic        fifo_rdempty;
  logic        fifo_rdfull;
  logic [2:0]  fifo_rdusedw;
  logic        fifo_rdreq;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        burst_done;

  always #5 rdclk = ~rdclk;

  fifo_burst_reader #(
    .DATA_W     (16),
    .USEDW_W    (3),
    .BURST_LEN  (4),
    .OBUF_DEPTH (4)
  ) dut (
    .rdclk        (rdclk),
    .aclr_n       (aclr_n),
    .fifo_q       (fifo_q),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdfull  (fifo_rdfull),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_rdreq   (fifo_rdreq),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .burst_done   (burst_done)
  );

  // ---------------- FIFO model (8 deep, show-after-rdreq) ----------------
  logic [15:0] fq[$];
  logic [15:0] push_q[$];
  logic        clr_req = 1'b0;
  logic        force_empty = 1'b0;
  logic        empty_m = 1'b1;
  logic        full_m = 1'b0;
  logic [2:0]  usedw_m = '0;

  assign fifo_rdempty = force_empty | empty_m;
  assign fifo_rdfull  = full_m;
  assign fifo_rdusedw = usedw_m;

  always @(posedge rdclk) begin
    if (clr_req) fq.delete();
    else if (fifo_rdreq && fq.size() > 0) fifo_q <= fq.pop_front();
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    empty_m <= (fq.size() == 0);
    full_m  <= (fq.size() == 8);
    usedw_m <= 3'(fq.size());
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   wcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  logic        stall_q = 1'b0;
  logic [15:0] stall_d = '0;
  logic        stall_l = 1'b0;

  always @(negedge rdclk) begin
    if (aclr_n) begin
      exp_t e;
      check("rdreq_while_empty", 32'(fifo_rdreq & fifo_rdempty), 32'd0);
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(stall_d));
        check("hold_last", 32'(out_last), 32'(stall_l));
      end
      if (out_valid && out_ready) begin
        check("sb_has_word", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_last", 32'(out_last), 32'(e.l));
          check("burst_done", 32'(burst_done), 32'(e.l));
        end
      end else begin
        check("burst_done_idle", 32'(burst_done), 32'd0);
      end
      stall_q <= out_valid & ~out_ready;
      stall_d <= out_data;
      stall_l <= out_last;
    end else begin
      stall_q <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic do_reset();
    aclr_n = 1'b0;
    clr_req = 1'b1;
    force_empty = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    push_q.delete();
    wcount = 0;
    tick();
    tick();
    clr_req = 1'b0;
    aclr_n = 1'b1;
    tick();
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = 16'(wcount + 1);
      e.l = ((wcount % 4) == 3);
      push_q.push_back(e.d);
      exp_q.push_back(e);
      wcount++;
    end
  endtask

  task automatic count_rdreq(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge rdclk);
      if (fifo_rdreq) c++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdreq"}, 32'(fifo_rdreq), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_done"}, 32'(burst_done), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
  endtask

  typedef struct {
    int n;        // words preloaded into the FIFO
    int exp_rq;   // rdreq cycles in the first 7-cycle window
    int exp_left; // words that must remain unread after draining
  } vec_t;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   c;
    int   k;

    vecs[0] = '{n: 3, exp_rq: 0, exp_left: 3};
    vecs[1] = '{n: 4, exp_rq: 4, exp_left: 0};
    vecs[2] = '{n: 7, exp_rq: 4, exp_left: 3};
    vecs[3] = '{n: 8, exp_rq: 4, exp_left: 0};  // rdfull=1, rdusedw=0

    #2;
    check_outputs_zero("reset");

    // Level sweep: below threshold, exact, partial second burst, full FIFO.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      check_outputs_zero("post_reset");
      preload(vecs[i].n);
      count_rdreq(7, c);
      check("rdreq_count", 32'(c), 32'(vecs[i].exp_rq));
      repeat (30) tick();
      check("words_left", 32'(exp_q.size()), 32'(vecs[i].exp_left));
    end

    // Level 3 held, then raised to 4: first rdreq in the exact expected cycle.
    do_reset();
    preload(3);
    count_rdreq(8, c);
    check("lvl3_no_rdreq", 32'(c), 32'd0);
    tick();
    preload(1);
    count_rdreq(2, c);
    check("lvl4_not_yet", 32'(c), 32'd0);
    count_rdreq(1, c);
    check("lvl4_start", 32'(c), 32'd1);
    count_rdreq(3, c);
    check("lvl4_back_to_back", 32'(c), 32'd3);
    repeat (20) tick();
    check("lvl4_drained", 32'(exp_q.size()), 32'd0);

    // out_ready toggling every cycle.
    do_reset();
    preload(8);
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 2) == 0;
      tick();
    end
    out_ready = 1'b1;
    repeat (10) tick();
    check("toggle_drained", 32'(exp_q.size()), 32'd0);

    // out_ready held low: credit limits requests to the buffer depth.
    do_reset();
    out_ready = 1'b0;
    preload(4);
    count_rdreq(12, c);
    check("stall_rdreq", 32'(c), 32'd4);
    check("stall_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    repeat (10) tick();
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // rdempty forced high after two requests pauses the burst.
    do_reset();
    preload(4);
    k = 0;
    for (int i = 0; i < 20 && k < 2; i++) begin
      @(negedge rdclk);
      if (fifo_rdreq) k++;
    end
    check("empty_two_seen", 32'(k), 32'd2);
    tick();
    force_empty = 1'b1;
    count_rdreq(6, c);
    check("empty_paused", 32'(c), 32'd0);
    check("empty_two_out", 32'(exp_q.size()), 32'd2);
    tick();
    force_empty = 1'b0;
    count_rdreq(4, c);
    check("empty_resumed", 32'(c), 32'd2);
    repeat (10) tick();
    check("empty_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-burst, then a clean restart.
    do_reset();
    preload(8);
    k = 0;
    for (int i = 0; i < 30 && exp_q.size() > 6; i++) begin
      @(negedge rdclk);
      #1;
      k++;
    end
    check("midburst_reached", 32'(exp_q.size()), 32'd6);
    aclr_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    do_reset();
    check_outputs_zero("restart");
    preload(4);
    count_rdreq(7, c);
    check("restart_rdreq", 32'(c), 32'd4);
    repeat (20) tick();
    check("restart_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side consumer for the dual-clock sample FIFO (16-bit data, 8 words deep, 3-bit used-word count). It runs entirely in the FIFO read clock domain. It waits until a full burst of samples is buffered, then drains exactly `BURST_LEN` words with correctly timed `rdreq` pulses and absorbs the FIFO's one-cycle read latency. It presents the words on a valid/ready stream, with a last-of-burst marker, to the downstream filter stage.

## Interface
- `DATA_W`, 16, sample width; must equal the FIFO `q` width.
- `USEDW_W`, 3, width of FIFO `rdusedw`; FIFO depth = 2^`USEDW_W`.
- `BURST_LEN`, 4, words per burst; legal range 1..2^`USEDW_W`.
- `OBUF_DEPTH`, 4, output buffer depth; power of 2, at least 2.
- `rdclk` in 1: read-domain clock, same net as the FIFO `rdclk`.
- `aclr_n` in 1: asynchronous active-low reset.
- `fifo_q` in `DATA_W`: FIFO read data, valid one cycle after `rdreq`.
- `fifo_rdempty` in 1: FIFO empty flag.
- `fifo_rdfull` in 1: FIFO full flag.
- `fifo_rdusedw` in `USEDW_W`: FIFO used-word count; reads 0 when full.
- `fifo_rdreq` out 1: FIFO read request.
- `out_data` out `DATA_W`: stream data.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: downstream ready.
- `out_last` out 1: marks the final word of a burst.
- `burst_done` out 1: one-cycle pulse when the last word of a burst is accepted downstream.

## Operation
- Level = `fifo_rdfull` ? 2^`USEDW_W` : `fifo_rdusedw`. Compute it at width `USEDW_W`+1.
- FSM states are IDLE, BURST and FLUSH.
- IDLE to BURST: level ≥ `BURST_LEN` and obuf is empty. On entry, load `issued` = 0.
- BURST: assert `fifo_rdreq` in a cycle only when all three hold: `issued` < `BURST_LEN`, `fifo_rdempty` = 0, and obuf occupancy + in-flight < `OBUF_DEPTH`. Each asserted cycle increments `issued`.
- BURST to FLUSH: in the cycle in which the `BURST_LEN`-th request is issued.
- FLUSH to IDLE: when the last-tagged word is accepted (`out_valid` & `out_ready` & `out_last`).
- Read pipe: a 1-stage valid/last shift register follows `fifo_rdreq`. One cycle after a request, it captures `fifo_q` plus its last tag into the obuf. The last tag is set when `issued` = `BURST_LEN`-1 at request time.
- Obuf: synchronous FIFO, show-ahead. `out_valid` = not empty. A pop occurs on `out_valid` & `out_ready`. A push and a pop in the same cycle are both legal, including when the obuf is full (the pop frees space first).
- Backpressure: the credit check guarantees no obuf overflow. No word is ever dropped or duplicated.
- `fifo_rdempty` asserting mid-burst pauses requests. The FSM stays in BURST; this is not an error.
- `fifo_rdreq` is never asserted while `fifo_rdempty` = 1 or outside BURST.

## Timing
- Reset values: `fifo_rdreq`=0, `out_valid`=0, `out_last`=0, `burst_done`=0, `out_data`=0, state IDLE, `issued`=0, obuf empty, read pipe cleared.
- Reset applied mid-burst discards in-flight and buffered words immediately. After release, the block restarts from IDLE.
- Latency: the first `rdreq` goes high the cycle after IDLE sees the burst condition, since the condition is registered.
- `rdreq` at edge t → `fifo_q` sampled at t+1 → `out_valid` at t+2 at the earliest.
- Throughput: 1 word/cycle with `out_ready` held high, e.g. 4 consecutive `rdreq` cycles for `BURST_LEN`=4.
- `burst_done` is high in the same cycle as the accepting handshake of the last word.
- Outputs hold stable while `out_valid` & !`out_ready`.

## Structure
- Shared package `fifo_rd_pkg`: the state enum (IDLE/BURST/FLUSH), default `DATA_W`/`USEDW_W`/`BURST_LEN` constants, and a level-width helper constant.
- One sub-module: `obuf_sync_fifo`, a single-clock show-ahead FIFO with `DATA_W`+1 width (data + last) and depth `OBUF_DEPTH`, reset by `aclr_n`.
- Top level (FSM, credit counter, read pipe): about 150–250 lines.

## Test plan
- FIFO preloaded with 1..8, `out_ready`=1 → 4 back-to-back `rdreq` cycles; output 1,2,3,4 with `out_last` on 4 and one `burst_done`; then a second burst 5..8.
- Level = 3 held → no `rdreq` at all. Raise level to 4 → burst starts on the next cycle.
- `out_ready` toggling 1/0 every cycle during a burst → no obuf overflow; sequence intact, no loss or duplicates; `rdreq` throttled.
- `fifo_rdempty` forced high after 2 words → `rdreq` stops. Clear it → remaining 2 words read; `out_last` only on word 4.
- `fifo_rdfull`=1 with `rdusedw`=0 → level taken as 8; burst starts.
- `aclr_n` pulsed low mid-burst → all outputs 0 asynchronously; after release the next burst starts cleanly from IDLE.
